// File: rtl/secure_cfg_access_gate.sv
// secure_cfg_access_gate
// Guards a config register file behind a privilege, unlock and lockout policy.
// Each request goes through CHECK, then ACCESS, then RESP. Only permitted
// downstream accesses reach the register file.
//
// Ports
//   clk, reset_n              clock; asynchronous active-low reset
//   req_*                     request channel (valid/ready, write, addr, wdata, priv)
//   resp_*                    response channel (valid/ready, err, rdata)
//   cfg_*                     downstream register file (addr, wdata, we, rdata)
//   unlocked, locked_out,     policy status
//   fail_count
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// CHECK  | decide permit/deny from latched request and policy state
// ACCESS | drive downstream for permitted accesses, capture read data
// RESP   | hold the response until resp_ready
module secure_cfg_access_gate #(
  parameter logic [31:0] UNLOCK_KEY     = 32'hC0DE5AFE,
  parameter int unsigned UNLOCK_WINDOW  = 64,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_priv,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [7:0]  cfg_address,
  output logic [31:0] cfg_write_data,
  output logic        cfg_write_enable,
  input  logic [31:0] cfg_read_data,
  output logic        unlocked,
  output logic        locked_out,
  output logic [1:0]  fail_count
);

  localparam int unsigned UW = $clog2(UNLOCK_WINDOW + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ACCESS, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          write_q, write_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    priv_q, priv_d;
  logic          rd_capture_q, rd_capture_d;
  logic [7:0]    cfg_address_q, cfg_address_d;
  logic [31:0]   cfg_write_data_q, cfg_write_data_d;
  logic          cfg_write_enable_q, cfg_write_enable_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          unlocked_q, unlocked_d;
  logic [UW-1:0] unlock_tmr_q, unlock_tmr_d;
  logic          locked_out_q, locked_out_d;
  logic [LW-1:0] lock_tmr_q, lock_tmr_d;
  logic [1:0]    fail_count_q, fail_count_d;

  logic          permit, use_dn, do_unlock, clr_unlock;
  logic [1:0]    fail_inc;

  always_comb begin
    state_d            = state_q;
    req_ready_d        = req_ready_q;
    write_d            = write_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    priv_d             = priv_q;
    rd_capture_d       = rd_capture_q;
    cfg_address_d      = cfg_address_q;
    cfg_write_data_d   = cfg_write_data_q;
    cfg_write_enable_d = cfg_write_enable_q;
    resp_valid_d       = resp_valid_q;
    resp_err_d         = resp_err_q;
    resp_rdata_d       = resp_rdata_q;
    unlocked_d         = unlocked_q;
    unlock_tmr_d       = unlock_tmr_q;
    locked_out_d       = locked_out_q;
    lock_tmr_d         = lock_tmr_q;
    fail_count_d       = fail_count_q;
    permit             = 1'b0;
    use_dn             = 1'b0;
    do_unlock          = 1'b0;
    clr_unlock         = 1'b0;
    fail_inc           = (fail_count_q == 2'b11) ? 2'b11 : fail_count_q + 2'd1;

    // Free-running timers; decisions below override them on the same edge.
    if (unlocked_q) begin
      if (unlock_tmr_q <= UW'(1)) begin
        unlock_tmr_d = '0;
        unlocked_d   = 1'b0;
      end else begin
        unlock_tmr_d = unlock_tmr_q - UW'(1);
      end
    end
    if (locked_out_q) begin
      unlocked_d   = 1'b0;
      unlock_tmr_d = '0;
      if (lock_tmr_q <= LW'(1)) begin
        lock_tmr_d   = '0;
        locked_out_d = 1'b0;
        fail_count_d = 2'b00;
      end else begin
        lock_tmr_d = lock_tmr_q - LW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          priv_d      = req_priv;
          req_ready_d = 1'b0;
          state_d     = S_CHECK;
        end else begin
          req_ready_d = 1'b1;
        end
      end

      S_CHECK: begin
        if (addr_q == 8'h1F) begin
          if (!write_q) begin
            permit = 1'b1;
          end else if (wdata_q == UNLOCK_KEY) begin
            permit    = 1'b1;
            do_unlock = 1'b1;
          end
        end else if (write_q && (addr_q == 8'h10 || addr_q == 8'h12)) begin
          if (unlocked_q && priv_q == 2'b11) begin
            permit     = 1'b1;
            use_dn     = 1'b1;
            clr_unlock = 1'b1;
          end
        end else if (addr_q == 8'h10) begin
          permit = 1'b0;
        end else if (addr_q == 8'h11) begin
          if (priv_q != 2'b00) begin
            permit = 1'b1;
            use_dn = 1'b1;
          end
        end else if (!write_q) begin
          permit = 1'b1;
          use_dn = 1'b1;
        end
        // Pre-edge locked_out wins even if lockout expires on this edge.
        if (locked_out_q) begin
          permit     = 1'b0;
          use_dn     = 1'b0;
          do_unlock  = 1'b0;
          clr_unlock = 1'b0;
        end

        resp_err_d   = !permit;
        resp_rdata_d = (permit && addr_q == 8'h1F && !write_q) ? {31'b0, unlocked_q} : 32'h0;
        rd_capture_d = permit && use_dn && !write_q;
        if (permit && use_dn) begin
          cfg_address_d = addr_q;
          if (write_q) begin
            cfg_write_enable_d = 1'b1;
            cfg_write_data_d   = wdata_q;
          end
        end
        if (do_unlock) begin
          unlocked_d   = 1'b1;
          unlock_tmr_d = UW'(UNLOCK_WINDOW);
          fail_count_d = 2'b00;
        end
        if (clr_unlock) begin
          unlocked_d   = 1'b0;
          unlock_tmr_d = '0;
        end
        if (!permit && !locked_out_q) begin
          fail_count_d = fail_inc;
          if (32'(fail_inc) >= MAX_FAIL) begin
            locked_out_d = 1'b1;
            lock_tmr_d   = LW'(LOCKOUT_CYCLES);
            unlocked_d   = 1'b0;
            unlock_tmr_d = '0;
          end
        end
        state_d = S_ACCESS;
      end

      S_ACCESS: begin
        if (rd_capture_q) begin
          resp_rdata_d = cfg_read_data;
        end
        rd_capture_d       = 1'b0;
        cfg_address_d      = 8'h00;
        cfg_write_data_d   = 32'h0;
        cfg_write_enable_d = 1'b0;
        resp_valid_d       = 1'b1;
        state_d            = S_RESP;
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      req_ready_q        <= 1'b0;
      write_q            <= 1'b0;
      addr_q             <= 8'h00;
      wdata_q            <= 32'h0;
      priv_q             <= 2'b00;
      rd_capture_q       <= 1'b0;
      cfg_address_q      <= 8'h00;
      cfg_write_data_q   <= 32'h0;
      cfg_write_enable_q <= 1'b0;
      resp_valid_q       <= 1'b0;
      resp_err_q         <= 1'b0;
      resp_rdata_q       <= 32'h0;
      unlocked_q         <= 1'b0;
      unlock_tmr_q       <= '0;
      locked_out_q       <= 1'b0;
      lock_tmr_q         <= '0;
      fail_count_q       <= 2'b00;
    end else begin
      state_q            <= state_d;
      req_ready_q        <= req_ready_d;
      write_q            <= write_d;
      addr_q             <= addr_d;
      wdata_q            <= wdata_d;
      priv_q             <= priv_d;
      rd_capture_q       <= rd_capture_d;
      cfg_address_q      <= cfg_address_d;
      cfg_write_data_q   <= cfg_write_data_d;
      cfg_write_enable_q <= cfg_write_enable_d;
      resp_valid_q       <= resp_valid_d;
      resp_err_q         <= resp_err_d;
      resp_rdata_q       <= resp_rdata_d;
      unlocked_q         <= unlocked_d;
      unlock_tmr_q       <= unlock_tmr_d;
      locked_out_q       <= locked_out_d;
      lock_tmr_q         <= lock_tmr_d;
      fail_count_q       <= fail_count_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_err         = resp_err_q;
  assign resp_rdata       = resp_rdata_q;
  assign cfg_address      = cfg_address_q;
  assign cfg_write_data   = cfg_write_data_q;
  assign cfg_write_enable = cfg_write_enable_q;
  assign unlocked         = unlocked_q;
  assign locked_out       = locked_out_q;
  assign fail_count       = fail_count_q;

endmodule

// File: tb/tb_secure_cfg_access_gate.sv
module tb_secure_cfg_access_gate;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_priv = 2'b00;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  cfg_address;
  logic [31:0] cfg_write_data;
  logic        cfg_write_enable;
  logic [31:0] cfg_read_data;
  logic        unlocked;
  logic        locked_out;
  logic [1:0]  fail_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file stand-in: read data is a recognisable function of the address.
  assign cfg_read_data = 32'h5A000000 | {24'h0, cfg_address};

  secure_cfg_access_gate dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_priv(req_priv),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .cfg_address(cfg_address), .cfg_write_data(cfg_write_data),
    .cfg_write_enable(cfg_write_enable), .cfg_read_data(cfg_read_data),
    .unlocked(unlocked), .locked_out(locked_out), .fail_count(fail_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    chk("rst_flags", {26'h0, resp_valid, resp_err, cfg_write_enable, unlocked, locked_out, req_ready}, 32'h0);
    chk("rst_data", resp_rdata | cfg_write_data | {24'h0, cfg_address} | {30'h0, fail_count}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_ready_after", {31'h0, req_ready}, 32'h1);
  endtask

  // One full transaction; hold>0 keeps resp_ready low for that many RESP cycles.
  task automatic do_req(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [1:0] p, input int at_cyc, input int hold,
                        output logic err, output logic [31:0] rd, output int we_cnt,
                        output logic [7:0] we_a, output logic [31:0] we_d,
                        output int dn_cnt, output int lat);
    int n;
    err = 1'b0; rd = 32'h0; we_cnt = 0; we_a = 8'h00; we_d = 32'h0; dn_cnt = 0; lat = 0;
    if (at_cyc > 0) begin
      while (cyc < at_cyc - 1) tick();
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_priv = p;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", {31'h0, req_ready}, 32'h1);
    tick();
    last_acc = cyc;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 32'h0; req_priv = 2'b00;
    resp_ready = (hold == 0);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      if (cfg_write_enable) begin
        we_cnt++;
        we_a = cfg_address;
        we_d = cfg_write_data;
      end
      if (cfg_address != 8'h00) dn_cnt++;
      tick();
      lat++;
    end
    if (!resp_valid) chk("resp_timeout", {31'h0, resp_valid}, 32'h1);
    err = resp_err;
    rd = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_err", {31'h0, resp_err}, {31'h0, err});
    end
    resp_ready = 1'b1;
    tick();
    chk("resp_valid_drop", {31'h0, resp_valid}, 32'h0);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  priv;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_we;
    int          exp_dn;
    logic [1:0]  exp_fail;
    logic        exp_unl;
  } vec_t;

  vec_t vecs[12];

  logic        e;
  logic [31:0] r;
  int          wc, dc, lt;
  logic [7:0]  wa;
  logic [31:0] wd;
  int          acc_u, acc_l;

  initial begin
    // wr addr wdata priv | err rdata we dn fail unlocked
    vecs[0]  = '{1'b0, 8'h12, 32'h0,        2'd0, 1'b0, 32'h5A000012, 0, 1, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 8'h40, 32'h0,        2'd0, 1'b0, 32'h5A000040, 0, 1, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 8'h11, 32'h0,        2'd1, 1'b0, 32'h5A000011, 0, 1, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 8'h11, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1, 1, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 8'h1F, 32'h0,        2'd0, 1'b0, 32'h0,        0, 0, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 8'h11, 32'h0,        2'd0, 1'b1, 32'h0,        0, 0, 2'd1, 1'b0};
    vecs[6]  = '{1'b1, 8'h1F, 32'hC0DE5AFE, 2'd0, 1'b0, 32'h0,        0, 0, 2'd0, 1'b1};
    vecs[7]  = '{1'b0, 8'h1F, 32'h0,        2'd0, 1'b0, 32'h1,        0, 0, 2'd0, 1'b1};
    vecs[8]  = '{1'b0, 8'h10, 32'h0,        2'd3, 1'b1, 32'h0,        0, 0, 2'd1, 1'b1};
    vecs[9]  = '{1'b1, 8'h10, 32'h12345678, 2'd3, 1'b0, 32'h0,        1, 1, 2'd1, 1'b0};
    vecs[10] = '{1'b0, 8'h1F, 32'h0,        2'd0, 1'b0, 32'h0,        0, 0, 2'd1, 1'b0};
    vecs[11] = '{1'b1, 8'h40, 32'h55,       2'd3, 1'b1, 32'h0,        0, 0, 2'd2, 1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].priv, 0, 0, e, r, wc, wa, wd, dc, lt);
      chk($sformatf("v%0d_err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_rdata", i), r, vecs[i].exp_rdata);
      chk($sformatf("v%0d_we_cnt", i), wc, vecs[i].exp_we);
      chk($sformatf("v%0d_dn_cnt", i), dc, vecs[i].exp_dn);
      chk($sformatf("v%0d_latency", i), lt, 3);
      chk($sformatf("v%0d_fail", i), {30'h0, fail_count}, {30'h0, vecs[i].exp_fail});
      chk($sformatf("v%0d_unlocked", i), {31'h0, unlocked}, {31'h0, vecs[i].exp_unl});
      if (vecs[i].exp_we != 0) begin
        chk($sformatf("v%0d_we_addr", i), {24'h0, wa}, {24'h0, vecs[i].addr});
        chk($sformatf("v%0d_we_data", i), wd, vecs[i].wdata);
      end
    end

    // Protected write without unlock, then a held response.
    do_reset();
    do_req(1'b1, 8'h12, 32'hF, 2'd3, 0, 0, e, r, wc, wa, wd, dc, lt);
    chk("prot_nounl_err", {31'h0, e}, 32'h1);
    chk("prot_nounl_we", wc, 0);
    chk("prot_nounl_fail", {30'h0, fail_count}, 32'h1);
    do_req(1'b0, 8'h11, 32'h0, 2'd1, 0, 5, e, r, wc, wa, wd, dc, lt);
    chk("held_rdata", r, 32'h5A000011);
    chk("held_err", {31'h0, e}, 32'h0);

    // Lockout after three bad unlocks; correct key refused while locked.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 8'h1F, 32'h0, 2'd3, 0, 0, e, r, wc, wa, wd, dc, lt);
      chk($sformatf("badkey%0d_err", i), {31'h0, e}, 32'h1);
      chk($sformatf("badkey%0d_fail", i), {30'h0, fail_count}, i + 1);
      chk($sformatf("badkey%0d_locked", i), {31'h0, locked_out}, (i == 2) ? 32'h1 : 32'h0);
    end
    acc_l = last_acc;
    do_req(1'b1, 8'h1F, 32'hC0DE5AFE, 2'd3, 0, 0, e, r, wc, wa, wd, dc, lt);
    chk("locked_unlock_err", {31'h0, e}, 32'h1);
    chk("locked_unlock_unl", {31'h0, unlocked}, 32'h0);
    chk("locked_fail_hold", {30'h0, fail_count}, 32'h3);
    while (cyc < acc_l + 256) tick();
    chk("lock_last_cycle", {31'h0, locked_out}, 32'h1);
    tick();
    chk("lock_expired", {31'h0, locked_out}, 32'h0);
    chk("lock_fail_clr", {30'h0, fail_count}, 32'h0);
    do_req(1'b0, 8'h12, 32'h0, 2'd0, 0, 0, e, r, wc, wa, wd, dc, lt);
    chk("post_lock_read", r, 32'h5A000012);

    // Unlock window edge: timer already expired vs. CHECK at timer=1.
    do_reset();
    do_req(1'b1, 8'h1F, 32'hC0DE5AFE, 2'd0, 0, 0, e, r, wc, wa, wd, dc, lt);
    acc_u = last_acc;
    do_req(1'b1, 8'h10, 32'hAAAA5555, 2'd3, acc_u + 65, 0, e, r, wc, wa, wd, dc, lt);
    chk("window_expired_err", {31'h0, e}, 32'h1);
    chk("window_expired_we", wc, 0);
    do_req(1'b1, 8'h1F, 32'hC0DE5AFE, 2'd0, 0, 0, e, r, wc, wa, wd, dc, lt);
    acc_u = last_acc;
    do_req(1'b1, 8'h10, 32'hAAAA5555, 2'd3, acc_u + 64, 0, e, r, wc, wa, wd, dc, lt);
    chk("window_last_err", {31'h0, e}, 32'h0);
    chk("window_last_we", wc, 1);
    chk("window_last_we_data", wd, 32'hAAAA5555);

    // Reset asserted while in ACCESS drops the request.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h11; req_wdata = 32'hCAFEF00D; req_priv = 2'd1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("access_we_before_rst", {31'h0, cfg_write_enable}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_kills_we", {31'h0, cfg_write_enable}, 32'h0);
    chk("rst_ready_low", {31'h0, req_ready}, 32'h0);
    tick();
    reset_n = 1'b1;
    wc = 0;
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cfg_write_enable) wc++;
      if (resp_valid) dc++;
    end
    chk("rst_no_we_after", wc, 0);
    chk("rst_no_resp", dc, 0);
    chk("rst_ready_back", {31'h0, req_ready}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
